spi_link_master: RTL and testbench

Byte-level SPI master that serves the packet manager's transceiver interface (tx_start/tx_data/tx_busy, rx_data/rx_done) and drives the external radio's SPI pins in mode 0, MSB first. Every transfer is full-duplex: one byte goes out on MOSI and one byte is captured from MISO. In receive mode (poll_en high), the block autonomously clocks filler bytes so incoming radio bytes reach the packet manager's sliding window. A one-deep pending slot guarantees a tx_start is never lost while a poll transfer is in flight.

---
 rtl/spi_link_pkg.sv | 27 ++
 rtl/spi_link_if.sv | 25 ++
 rtl/spi_shift_core.sv | 94 +++++++++
 rtl/spi_link_master.sv | 198 +++++++++++++++++++
 tb/tb_spi_link_master.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_link_pkg.sv
// Shared definitions for the SPI link master: FSM state encoding, byte width,
// default poll filler byte and a counter-width helper.
package spi_link_pkg;

    localparam int unsigned SPI_BYTE_W = 8;
    localparam logic [SPI_BYTE_W-1:0] IDLE_BYTE_DEF = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } link_state_t;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        if (w < 32'd1) begin
            w = 32'd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/spi_link_if.sv
// Transceiver interface between the packet manager and the SPI link master.
//   master modport: packet manager (drives tx_start/tx_data/poll_en)
//   slave  modport: spi_link_master (drives tx_busy/rx_data/rx_done/overflow)
interface spi_link_if;
    import spi_link_pkg::*;

    logic                  tx_start;
    logic [SPI_BYTE_W-1:0] tx_data;
    logic                  tx_busy;
    logic [SPI_BYTE_W-1:0] rx_data;
    logic                  rx_done;
    logic                  poll_en;
    logic                  overflow;

    modport master (
        output tx_start, tx_data, poll_en,
        input  tx_busy, rx_data, rx_done, overflow
    );

    modport slave (
        input  tx_start, tx_data, poll_en,
        output tx_busy, rx_data, rx_done, overflow
    );

endinterface

// File: rtl/spi_shift_core.sv
// SPI mode-0 byte shifter: SCLK divider, edge counter, MOSI shift-out (MSB
// first) and MISO capture through a 2-flop synchroniser.
//   load        : preload byte_in, drive its MSB on MOSI, park SCLK low
//   start_shift : begin the 16-edge SCLK sequence on the next cycle
//   shift_done  : high in the cycle whose edge produces the 8th falling SCLK
//   byte_out    : captured MISO byte
module spi_shift_core
    import spi_link_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [SPI_BYTE_W-1:0] byte_in,
    input  logic                  start_shift,
    output logic                  shift_done,
    output logic [SPI_BYTE_W-1:0] byte_out,
    input  logic                  spi_miso,
    output logic                  spi_sclk,
    output logic                  spi_mosi
);

    localparam int unsigned      DIV_W    = cnt_w(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]      div_cnt_r;
    logic [3:0]            edge_cnt_r;
    logic                  running_r;
    logic                  sclk_r;
    logic                  mosi_r;
    logic [SPI_BYTE_W-2:0] tx_shift_r;
    logic [SPI_BYTE_W-1:0] rx_shift_r;
    logic [1:0]            miso_sync_r;
    logic                  tick_s;

    // Even edge index = SCLK rising, odd = falling; index 15 is the last fall.
    assign tick_s     = running_r && (div_cnt_r == DIV_LAST);
    assign shift_done = tick_s && (edge_cnt_r == 4'd15);
    assign byte_out   = rx_shift_r;
    assign spi_sclk   = sclk_r;
    assign spi_mosi   = mosi_r;

    // Two-flop synchroniser for the asynchronous MISO pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_sync_r <= 2'b00;
        end else begin
            miso_sync_r <= {miso_sync_r[0], spi_miso};
        end
    end

    // Divider, SCLK toggling and data shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            edge_cnt_r <= 4'd0;
            running_r  <= 1'b0;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            tx_shift_r <= {(SPI_BYTE_W-1){1'b0}};
            rx_shift_r <= {SPI_BYTE_W{1'b0}};
        end else if (load) begin
            tx_shift_r <= byte_in[SPI_BYTE_W-2:0];
            mosi_r     <= byte_in[SPI_BYTE_W-1];
            running_r  <= 1'b0;
            div_cnt_r  <= {DIV_W{1'b0}};
            edge_cnt_r <= 4'd0;
            sclk_r     <= 1'b0;
        end else if (start_shift) begin
            running_r  <= 1'b1;
            div_cnt_r  <= {DIV_W{1'b0}};
            edge_cnt_r <= 4'd0;
            sclk_r     <= 1'b0;
        end else if (tick_s) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            edge_cnt_r <= edge_cnt_r + 4'd1;
            if (!edge_cnt_r[0]) begin
                sclk_r     <= 1'b1;
                rx_shift_r <= {rx_shift_r[SPI_BYTE_W-2:0], miso_sync_r[1]};
            end else if (edge_cnt_r == 4'd15) begin
                sclk_r    <= 1'b0;
                running_r <= 1'b0;
            end else begin
                sclk_r     <= 1'b0;
                mosi_r     <= tx_shift_r[SPI_BYTE_W-2];
                tx_shift_r <= {tx_shift_r[SPI_BYTE_W-3:0], 1'b0};
            end
        end else if (running_r) begin
            div_cnt_r <= div_cnt_r + 1'b1;
        end
    end

endmodule

// File: rtl/spi_link_master.sv
// Byte-level SPI master (mode 0, MSB first) serving the packet manager.
// Holds the transfer FSM, a one-deep pending slot, the poll-gap counter and
// the sticky overflow flag; bit timing lives in spi_shift_core.
//   clk, rst_n      : clock, async active-low reset
//   link (slave)    : tx_start/tx_data/poll_en in, tx_busy/rx_data/rx_done/overflow out
//   spi_sclk/mosi/cs_n out, spi_miso in : radio SPI pins
module spi_link_master
    import spi_link_pkg::*;
#(
    parameter int unsigned           CLK_DIV   = 4,
    parameter int unsigned           CS_SETUP  = 2,
    parameter int unsigned           CS_HOLD   = 2,
    parameter int unsigned           POLL_GAP  = 64,
    parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    spi_link_if.slave link,
    output logic      spi_sclk,
    output logic      spi_mosi,
    input  logic      spi_miso,
    output logic      spi_cs_n
);

    localparam int unsigned       PH_MAX     = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned       PH_W       = cnt_w(PH_MAX);
    localparam int unsigned       POLL_W     = cnt_w(POLL_GAP);
    localparam logic [PH_W-1:0]   SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]   HOLD_LAST  = PH_W'(CS_HOLD - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_GAP - 1);

    link_state_t           state_r;
    logic [PH_W-1:0]       phase_cnt_r;
    logic [POLL_W-1:0]     poll_cnt_r;
    logic                  pend_full_r;
    logic [SPI_BYTE_W-1:0] pend_data_r;
    logic                  busy_r;
    logic [SPI_BYTE_W-1:0] rx_data_r;
    logic                  rx_done_r;
    logic                  overflow_r;
    logic                  cs_n_r;

    logic                  setup_last_s;
    logic                  hold_last_s;
    logic                  chain_s;
    logic                  poll_fire_s;
    logic                  load_s;
    logic [SPI_BYTE_W-1:0] load_byte_s;
    logic                  start_shift_s;
    logic                  shift_done_s;
    logic [SPI_BYTE_W-1:0] byte_out_s;

    assign setup_last_s = (state_r == SETUP) && (phase_cnt_r == SETUP_LAST);
    assign hold_last_s  = (state_r == HOLD) && (phase_cnt_r == HOLD_LAST);
    // A request arriving on the final HOLD cycle with an empty slot is chained
    // straight into the next transfer so it cannot be stranded in the slot.
    assign chain_s      = hold_last_s && (pend_full_r || link.tx_start);
    assign poll_fire_s  = link.poll_en && (poll_cnt_r == POLL_LAST);

    assign link.tx_busy  = busy_r;
    assign link.rx_data  = rx_data_r;
    assign link.rx_done  = rx_done_r;
    assign link.overflow = overflow_r;
    assign spi_cs_n      = cs_n_r;

    // Select what the shift core loads and when it starts shifting.
    always_comb begin
        load_s        = 1'b0;
        load_byte_s   = {SPI_BYTE_W{1'b0}};
        start_shift_s = 1'b0;
        if (state_r == IDLE) begin
            if (link.tx_start) begin
                load_s      = 1'b1;
                load_byte_s = link.tx_data;
            end else if (poll_fire_s) begin
                load_s      = 1'b1;
                load_byte_s = IDLE_BYTE;
            end else begin
                load_s = 1'b0;
            end
        end else if (chain_s) begin
            load_s      = 1'b1;
            load_byte_s = pend_full_r ? pend_data_r : link.tx_data;
        end else if (setup_last_s) begin
            start_shift_s = 1'b1;
        end else begin
            start_shift_s = 1'b0;
        end
    end

    // Transfer FSM with registered handshake outputs and poll-gap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            phase_cnt_r <= {PH_W{1'b0}};
            poll_cnt_r  <= {POLL_W{1'b0}};
            busy_r      <= 1'b0;
            rx_data_r   <= {SPI_BYTE_W{1'b0}};
            rx_done_r   <= 1'b0;
            cs_n_r      <= 1'b1;
        end else begin
            rx_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        state_r     <= SETUP;
                        phase_cnt_r <= {PH_W{1'b0}};
                        cs_n_r      <= 1'b0;
                        busy_r      <= 1'b1;
                        poll_cnt_r  <= {POLL_W{1'b0}};
                    end else if (link.poll_en) begin
                        poll_cnt_r <= poll_cnt_r + 1'b1;
                    end else begin
                        poll_cnt_r <= {POLL_W{1'b0}};
                    end
                end
                SETUP: begin
                    // Re-asserts chip select after a chained transfer's 1-cycle gap.
                    cs_n_r     <= 1'b0;
                    poll_cnt_r <= {POLL_W{1'b0}};
                    if (setup_last_s) begin
                        phase_cnt_r <= {PH_W{1'b0}};
                        state_r     <= SHIFT;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 1'b1;
                    end
                end
                SHIFT: begin
                    poll_cnt_r <= {POLL_W{1'b0}};
                    if (shift_done_s) begin
                        phase_cnt_r <= {PH_W{1'b0}};
                        state_r     <= HOLD;
                    end
                end
                HOLD: begin
                    poll_cnt_r <= {POLL_W{1'b0}};
                    if (hold_last_s) begin
                        cs_n_r      <= 1'b1;
                        rx_data_r   <= byte_out_s;
                        rx_done_r   <= 1'b1;
                        phase_cnt_r <= {PH_W{1'b0}};
                        if (chain_s) begin
                            state_r <= SETUP;
                        end else begin
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end
                    end else begin
                        phase_cnt_r <= phase_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    phase_cnt_r <= {PH_W{1'b0}};
                    poll_cnt_r  <= {POLL_W{1'b0}};
                    busy_r      <= 1'b0;
                    cs_n_r      <= 1'b1;
                end
            endcase
        end
    end

    // One-deep pending slot and sticky overflow for requests made while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full_r <= 1'b0;
            pend_data_r <= {SPI_BYTE_W{1'b0}};
            overflow_r  <= 1'b0;
        end else if (link.tx_start && (state_r != IDLE)) begin
            if (hold_last_s && !pend_full_r) begin
                pend_full_r <= 1'b0;
            end else if (!pend_full_r || hold_last_s) begin
                pend_data_r <= link.tx_data;
                pend_full_r <= 1'b1;
            end else begin
                overflow_r <= 1'b1;
            end
        end else if (hold_last_s && pend_full_r) begin
            pend_full_r <= 1'b0;
        end
    end

    spi_shift_core #(
        .CLK_DIV (CLK_DIV)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load_s),
        .byte_in     (load_byte_s),
        .start_shift (start_shift_s),
        .shift_done  (shift_done_s),
        .byte_out    (byte_out_s),
        .spi_miso    (spi_miso),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi)
    );

endmodule

// File: tb/tb_spi_link_master.sv
// Self-checking bench for spi_link_master with default parameters: a mode-0
// radio model, a scoreboard of expected MOSI/MISO bytes per transfer, and
// cycle monitors for busy and chip-select timing.
module tb_spi_link_master;
    import spi_link_pkg::*;

    typedef struct packed {
        logic [7:0] mosi;
        logic [7:0] rx;
        logic       busy;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;
    logic spi_cs_n;

    spi_link_if link();

    spi_link_master dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .link     (link),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n)
    );

    always #5 clk = ~clk;

    int   chk_cnt = 0;
    int   fail_cnt = 0;
    int   cyc = 0;
    int   rx_cnt = 0;
    int   rx_cyc = 0;
    int   busy_run = 0;
    int   last_busy_len = 0;
    int   cs_low_run = 0;
    int   last_cs_low_len = 0;
    int   cs_high_run = 0;
    int   last_cs_high_len = 0;
    int   cs_fall_q[$];
    exp_t sb_q[$];
    exp_t sb_e;
    logic [7:0] miso_byte = 8'h00;
    logic [7:0] mosi_cap = 8'h00;
    int   mosi_bits = 0;
    int   miso_idx = -1;
    logic prev_cs = 1'b1;
    logic prev_sclk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] m, input logic [7:0] r, input logic b);
        exp_t e;
        e.mosi = m;
        e.rx   = r;
        e.busy = b;
        sb_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d);
        link.tx_data  = d;
        link.tx_start = 1'b1;
        @(negedge clk);
        link.tx_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (link.tx_busy === 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(link.tx_busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_rx(input int n, input string tag);
        int k = 0;
        while (rx_cnt < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, rx_cnt, n);
        @(negedge clk);
    endtask

    always @(posedge clk) cyc++;

    // Radio model, timing monitors and scoreboard, all sampled mid-cycle.
    always @(negedge clk) begin
        if (prev_cs && !spi_cs_n) begin
            spi_miso  = miso_byte[7];
            miso_idx  = 6;
            mosi_cap  = 8'h00;
            mosi_bits = 0;
        end else if (!spi_cs_n && prev_sclk && !spi_sclk && miso_idx >= 0) begin
            spi_miso = miso_byte[miso_idx];
            miso_idx--;
        end
        if (!spi_cs_n && !prev_sclk && spi_sclk) begin
            mosi_cap = {mosi_cap[6:0], spi_mosi};
            mosi_bits++;
        end

        if (link.tx_busy === 1'b1) begin
            busy_run++;
        end else begin
            if (busy_run != 0) last_busy_len = busy_run;
            busy_run = 0;
        end
        if (spi_cs_n === 1'b0) begin
            if (prev_cs) begin
                last_cs_high_len = cs_high_run;
                cs_fall_q.push_back(cyc);
            end
            cs_high_run = 0;
            cs_low_run++;
        end else begin
            if (cs_low_run != 0) last_cs_low_len = cs_low_run;
            cs_low_run = 0;
            cs_high_run++;
        end

        if (rst_n && link.rx_done === 1'b1) begin
            rx_cnt++;
            rx_cyc = cyc;
            if (sb_q.size() == 0) begin
                chk("rx_unexpected", sb_q.size(), 1);
            end else begin
                sb_e = sb_q.pop_front();
                chk("rx_data", 32'(link.rx_data), 32'(sb_e.rx));
                chk("mosi_byte", 32'(mosi_cap), 32'(sb_e.mosi));
                chk("mosi_bits", mosi_bits, 8);
                chk("busy_at_done", 32'(link.tx_busy), 32'(sb_e.busy));
            end
        end
        prev_cs   = spi_cs_n;
        prev_sclk = spi_sclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int k;
        int n_rx;
        int n_fall;
        link.tx_start = 1'b0;
        link.tx_data  = 8'h00;
        link.poll_en  = 1'b0;
        spi_miso      = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(link.tx_busy), 32'd0);
        chk("rst_rx_data", 32'(link.rx_data), 32'd0);
        chk("rst_rx_done", 32'(link.rx_done), 32'd0);
        chk("rst_overflow", 32'(link.overflow), 32'd0);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single byte, timing against the launch edge
        miso_byte = 8'h5A;
        push(8'hCA, 8'h5A, 1'b0);
        send(8'hCA);
        t0 = cyc;
        chk("t1_busy_next", 32'(link.tx_busy), 32'd1);
        chk("t1_cs_next", 32'(spi_cs_n), 32'd0);
        wait_idle("t1_idle");
        chk("t1_busy_len", last_busy_len, 68);
        chk("t1_cs_low_len", last_cs_low_len, 68);
        chk("t1_done_cycle", rx_cyc - t0, 68);
        chk("t1_rx_hold", 32'(link.rx_data), 32'h5A);
        chk("t1_rx_cnt", rx_cnt, 1);

        // 2: back-to-back sync word
        miso_byte = 8'h96;
        push(8'hCA, 8'h96, 1'b0);
        send(8'hCA);
        wait_idle("t2_idle_a");
        push(8'hFE, 8'h96, 1'b0);
        send(8'hFE);
        wait_idle("t2_idle_b");
        chk("t2_rx_cnt", rx_cnt, 3);
        chk("t2_overflow", 32'(link.overflow), 32'd0);

        // 3: autonomous polling
        miso_byte = 8'h3C;
        cs_fall_q.delete();
        push(8'h00, 8'h3C, 1'b0);
        push(8'h00, 8'h3C, 1'b0);
        link.poll_en = 1'b1;
        t0 = cyc;
        wait_rx(5, "t3_rx_cnt");
        link.poll_en = 1'b0;
        chk("t3_falls", cs_fall_q.size(), 2);
        if (cs_fall_q.size() >= 2) begin
            chk("t3_first_fall", cs_fall_q[0] - t0, 64);
            chk("t3_period", cs_fall_q[1] - cs_fall_q[0], 132);
        end
        repeat (4) @(negedge clk);

        // 4: request arrives during a poll transfer
        push(8'h00, 8'h3C, 1'b1);
        link.poll_en = 1'b1;
        k = 0;
        while (spi_cs_n === 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t4_poll_start", 32'(spi_cs_n), 32'd0);
        repeat (20) @(negedge clk);
        push(8'hA5, 8'h3C, 1'b0);
        link.poll_en = 1'b0;
        send(8'hA5);
        wait_idle("t4_idle");
        chk("t4_busy_len", last_busy_len, 136);
        chk("t4_cs_gap", last_cs_high_len, 1);
        chk("t4_cs_low_len", last_cs_low_len, 67);
        chk("t4_overflow", 32'(link.overflow), 32'd0);
        chk("t4_rx_cnt", rx_cnt, 7);

        // 5: third request in one transfer overflows
        miso_byte = 8'hE1;
        push(8'h11, 8'hE1, 1'b1);
        send(8'h11);
        repeat (10) @(negedge clk);
        push(8'h22, 8'hE1, 1'b0);
        send(8'h22);
        chk("t5_ovf_before", 32'(link.overflow), 32'd0);
        repeat (10) @(negedge clk);
        send(8'h33);
        chk("t5_ovf_set", 32'(link.overflow), 32'd1);
        wait_idle("t5_idle");
        chk("t5_ovf_sticky", 32'(link.overflow), 32'd1);
        chk("t5_rx_cnt", rx_cnt, 9);
        chk("t5_sb_empty", sb_q.size(), 0);

        // 6: reset during SHIFT with a pending byte
        miso_byte = 8'h0F;
        send(8'h77);
        @(negedge clk);
        k = 0;
        while (mosi_bits < 4 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t6_bits", mosi_bits, 4);
        send(8'h88);
        n_rx   = rx_cnt;
        n_fall = cs_fall_q.size();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_cs_n", 32'(spi_cs_n), 32'd1);
        chk("t6_sclk", 32'(spi_sclk), 32'd0);
        chk("t6_busy", 32'(link.tx_busy), 32'd0);
        chk("t6_rx_done", 32'(link.rx_done), 32'd0);
        chk("t6_ovf_clr", 32'(link.overflow), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("t6_no_rx_done", rx_cnt, n_rx);
        chk("t6_no_relaunch", cs_fall_q.size(), n_fall);
        chk("t6_busy_after", 32'(link.tx_busy), 32'd0);
        chk("t6_cs_after", 32'(spi_cs_n), 32'd1);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
